// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder: turns symbolic instruction descriptors into 32-bit MIPS
// words, buffers them in a small FIFO and writes them to IMEM sequentially
// from a programmable base byte address.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; descriptors ignored
// LOAD  | accepting descriptors, encoding and queueing, writing IMEM
// FLUSH | last descriptor accepted; draining the FIFO into IMEM
// DONE  | one-cycle end-of-session pulse on done
module mips_instr_encoder #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [4:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ready,
    output logic              busy,
    output logic              done,
    output logic              bad_op,
    output logic [CNT_W-1:0]  word_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FIFO_MAX = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        K_R   = 2'd0,
        K_I   = 2'd1,
        K_J   = 2'd2,
        K_BAD = 2'd3
    } kind_t;

    state_t           state;
    logic [31:0]      fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   fifo_cnt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             accept;
    logic             push;
    logic             pop;

    kind_t            kind;
    logic [5:0]       funct;
    logic [5:0]       opcode;
    logic             is_shift;
    logic [31:0]      enc_word;

    assign fifo_full  = (fifo_cnt == FIFO_MAX);
    assign fifo_empty = (fifo_cnt == '0);

    assign in_ready   = (state == S_LOAD) && !fifo_full;
    assign accept     = in_valid && in_ready;
    assign push       = accept && (kind != K_BAD);

    assign imem_we    = !fifo_empty && ((state == S_LOAD) || (state == S_FLUSH));
    assign imem_wdata = fifo_mem[rd_ptr];
    assign pop        = imem_we && imem_ready;

    assign busy       = (state == S_LOAD) || (state == S_FLUSH);
    assign done       = (state == S_DONE);

    // Decode the op select into instruction class and funct/opcode fields
    always_comb begin
        kind     = K_R;
        funct    = 6'b000000;
        opcode   = 6'b000000;
        is_shift = 1'b0;
        case (in_op)
            5'd0:  funct = 6'b100000;
            5'd1:  funct = 6'b100010;
            5'd2:  funct = 6'b100100;
            5'd3:  funct = 6'b100101;
            5'd4:  funct = 6'b101010;
            5'd5:  funct = 6'b100110;
            5'd6:  begin funct = 6'b000000; is_shift = 1'b1; end
            5'd7:  begin funct = 6'b000010; is_shift = 1'b1; end
            5'd8:  funct = 6'b101100;
            5'd9:  begin kind = K_I; opcode = 6'b001000; end
            5'd10: begin kind = K_I; opcode = 6'b001100; end
            5'd11: begin kind = K_I; opcode = 6'b001101; end
            5'd12: begin kind = K_I; opcode = 6'b001010; end
            5'd13: begin kind = K_I; opcode = 6'b100011; end
            5'd14: begin kind = K_I; opcode = 6'b101011; end
            5'd15: begin kind = K_I; opcode = 6'b000100; end
            5'd16: begin kind = K_I; opcode = 6'b000101; end
            5'd17: begin kind = K_J; opcode = 6'b000010; end
            default: kind = K_BAD;
        endcase
    end

    // Assemble the 32-bit word; shifts take shamt and drop rs, others the reverse
    always_comb begin
        enc_word = 32'h0;
        case (kind)
            K_R: enc_word = {6'b000000, (is_shift ? 5'd0 : in_rs), in_rt, in_rd,
                             (is_shift ? in_shamt : 5'd0), funct};
            K_I: enc_word = {opcode, in_rs, in_rt, in_imm};
            K_J: enc_word = {opcode, in_target};
            default: enc_word = 32'h0;
        endcase
    end

    // FIFO storage; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= enc_word;
        end
    end

    // Session FSM, FIFO pointers, address counter and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            imem_addr  <= '0;
            word_count <= '0;
            bad_op     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + PTR_W'(1);
                imem_addr  <= imem_addr + ADDR_W'(4);
                if (word_count != '1) begin
                    word_count <= word_count + CNT_W'(1);
                end
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (PTR_W + 1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (PTR_W + 1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (accept && (kind == K_BAD)) begin
                bad_op <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_LOAD;
                        imem_addr  <= base_addr;
                        word_count <= '0;
                        bad_op     <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (accept && in_last) begin
                        state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (fifo_empty) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed bench for mips_instr_encoder: a table of descriptors with
// hand-encoded words, plus hand-written sequences for backpressure,
// invalid ops, address wrap and reset during flush.
module tb_mips_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [4:0]  in_op, in_rs, in_rt, in_rd, in_shamt;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        imem_ready;
    logic        busy;
    logic        done;
    logic        bad_op;
    logic [15:0] word_count;

    always #5 clk = ~clk;

    mips_instr_encoder #(.ADDR_W(32), .DEPTH(4), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .in_op      (in_op),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .in_shamt   (in_shamt),
        .in_imm     (in_imm),
        .in_target  (in_target),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .imem_ready (imem_ready),
        .busy       (busy),
        .done       (done),
        .bad_op     (bad_op),
        .word_count (word_count)
    );

    typedef struct {
        logic [4:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] exp;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    int          done_cnt = 0;
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    vec_t        vecs[18];
    vec_t        bp[6];

    // Write and done monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst && imem_we && imem_ready) begin
            wa_q.push_back(imem_addr);
            wd_q.push_back(imem_wdata);
        end
        if (done) done_cnt++;
    end

    function automatic vec_t mk(input logic [4:0] op, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] rd,
                                input logic [4:0] sh, input logic [15:0] imm,
                                input logic [25:0] tgt, input logic [31:0] exp);
        vec_t v;
        v.op = op; v.rs = rs; v.rt = rt; v.rd = rd; v.sh = sh;
        v.imm = imm; v.tgt = tgt; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic send(input vec_t v, input logic last);
        bit ok = 0;
        in_op = v.op; in_rs = v.rs; in_rt = v.rt; in_rd = v.rd; in_shamt = v.sh;
        in_imm = v.imm; in_target = v.tgt; in_last = last;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ok) timeout("send");
    endtask

    task automatic start_session(input logic [31:0] base);
        @(posedge clk);
        #1;
        wa_q.delete();
        wd_q.delete();
        start = 1'b1;
        base_addr = base;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeout("wait_done");
    endtask

    initial begin
        int d0;
        vec_t bad;

        rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
        in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0;
        in_imm = '0; in_target = '0; imem_ready = 1'b1;

        vecs[0]  = mk(5'd9,  5'd0,  5'd8,  5'd0, 5'd0, 16'h0005, 26'h0,  32'h20080005);
        vecs[1]  = mk(5'd13, 5'd29, 5'd9,  5'd0, 5'd0, 16'h0004, 26'h0,  32'h8FA90004);
        vecs[2]  = mk(5'd16, 5'd1,  5'd2,  5'd0, 5'd0, 16'hFFFE, 26'h0,  32'h1422FFFE);
        vecs[3]  = mk(5'd17, 5'd0,  5'd0,  5'd0, 5'd0, 16'h0000, 26'h10, 32'h08000010);
        vecs[4]  = mk(5'd6,  5'd7,  5'd2,  5'd4, 5'd3, 16'h0000, 26'h0,  32'h000220C0);
        vecs[5]  = mk(5'd1,  5'd4,  5'd5,  5'd6, 5'd7, 16'h0000, 26'h0,  32'h00853022);
        vecs[6]  = mk(5'd2,  5'd1,  5'd1,  5'd1, 5'd0, 16'h0000, 26'h0,  32'h00210824);
        vecs[7]  = mk(5'd3,  5'd2,  5'd3,  5'd4, 5'd0, 16'h0000, 26'h0,  32'h00432025);
        vecs[8]  = mk(5'd4,  5'd1,  5'd2,  5'd3, 5'd0, 16'h0000, 26'h0,  32'h0022182A);
        vecs[9]  = mk(5'd5,  5'd1,  5'd2,  5'd3, 5'd0, 16'h0000, 26'h0,  32'h00221826);
        vecs[10] = mk(5'd7,  5'd9,  5'd2,  5'd4, 5'd1, 16'h0000, 26'h0,  32'h00022042);
        vecs[11] = mk(5'd8,  5'd1,  5'd2,  5'd3, 5'd0, 16'h0000, 26'h0,  32'h0022182C);
        vecs[12] = mk(5'd10, 5'd1,  5'd2,  5'd0, 5'd0, 16'h00FF, 26'h0,  32'h302200FF);
        vecs[13] = mk(5'd11, 5'd3,  5'd4,  5'd0, 5'd0, 16'h1234, 26'h0,  32'h34641234);
        vecs[14] = mk(5'd12, 5'd1,  5'd2,  5'd0, 5'd0, 16'h8000, 26'h0,  32'h28228000);
        vecs[15] = mk(5'd14, 5'd29, 5'd31, 5'd0, 5'd0, 16'h0008, 26'h0,  32'hAFBF0008);
        vecs[16] = mk(5'd15, 5'd0,  5'd0,  5'd0, 5'd0, 16'h0003, 26'h0,  32'h10000003);
        vecs[17] = mk(5'd0,  5'd1,  5'd2,  5'd3, 5'd0, 16'h0000, 26'h0,  32'h00221820);
        for (int k = 0; k < 6; k++)
            bp[k] = mk(5'd9, 5'd0, 5'd1, 5'd0, 5'd0, 16'(k + 1), 26'h0, 32'h20010000 + 32'(k + 1));
        bad = mk(5'd20, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h0);

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_imem_we", 32'(imem_we), 32'h0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_bad_op", 32'(bad_op), 32'h0);
        chk("rst_word_count", 32'(word_count), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // single ADD session
        start_session(32'h100);
        chk("s1_busy", 32'(busy), 32'h1);
        send(vecs[17], 1'b1);
        d0 = done_cnt;
        wait_done();
        chk("s1_nwrites", 32'(wa_q.size()), 32'h1);
        if (wa_q.size() >= 1) begin
            chk("s1_addr", wa_q[0], 32'h100);
            chk("s1_data", wd_q[0], 32'h00221820);
        end
        @(posedge clk);
        #1;
        chk("s1_done_once", 32'(done_cnt - d0), 32'h1);
        chk("s1_word_count", 32'(word_count), 32'h1);
        chk("s1_idle_ready", 32'(in_ready), 32'h0);

        // full encoding table in one stream from address 0
        start_session(32'h0);
        for (int i = 0; i < 18; i++) send(vecs[i], i == 17);
        wait_done();
        chk("tbl_nwrites", 32'(wa_q.size()), 32'd18);
        for (int i = 0; i < 18 && i < wa_q.size(); i++) begin
            chk($sformatf("tbl_addr[%0d]", i), wa_q[i], 32'(i * 4));
            chk($sformatf("tbl_data[%0d]", i), wd_q[i], vecs[i].exp);
        end
        chk("tbl_word_count", 32'(word_count), 32'd18);
        chk("tbl_bad_op", 32'(bad_op), 32'h0);

        // backpressure: FIFO fills at 4, outputs hold while imem_ready=0
        imem_ready = 1'b0;
        start_session(32'h200);
        for (int i = 0; i < 4; i++) send(bp[i], 1'b0);
        in_op = bp[4].op; in_rt = bp[4].rt; in_imm = bp[4].imm; in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'h0);
            chk("bp_we", 32'(imem_we), 32'h1);
            chk("bp_addr", imem_addr, 32'h200);
            chk("bp_data", imem_wdata, bp[0].exp);
        end
        chk("bp_word_count", 32'(word_count), 32'h0);
        imem_ready = 1'b1;
        send(bp[4], 1'b0);
        send(bp[5], 1'b1);
        wait_done();
        chk("bp_nwrites", 32'(wa_q.size()), 32'd6);
        for (int i = 0; i < 6 && i < wa_q.size(); i++) begin
            chk($sformatf("bp_waddr[%0d]", i), wa_q[i], 32'h200 + 32'(i * 4));
            chk($sformatf("bp_wdata[%0d]", i), wd_q[i], bp[i].exp);
        end

        // invalid op mid-stream
        start_session(32'h300);
        send(vecs[17], 1'b0);
        send(bad, 1'b0);
        chk("bad_set", 32'(bad_op), 32'h1);
        send(vecs[5], 1'b1);
        wait_done();
        chk("bad_nwrites", 32'(wa_q.size()), 32'd2);
        if (wa_q.size() >= 2) begin
            chk("bad_addr0", wa_q[0], 32'h300);
            chk("bad_data0", wd_q[0], 32'h00221820);
            chk("bad_addr1", wa_q[1], 32'h304);
            chk("bad_data1", wd_q[1], 32'h00853022);
        end
        repeat (3) @(negedge clk);
        chk("bad_sticky_idle", 32'(bad_op), 32'h1);
        chk("bad_word_count", 32'(word_count), 32'd2);

        // invalid op carrying in_last still ends the session
        start_session(32'h380);
        chk("bad_cleared", 32'(bad_op), 32'h0);
        send(bad, 1'b1);
        wait_done();
        chk("badlast_nwrites", 32'(wa_q.size()), 32'h0);
        chk("badlast_bad_op", 32'(bad_op), 32'h1);

        // address wrap
        start_session(32'hFFFFFFFC);
        chk("wrap_bad_cleared", 32'(bad_op), 32'h0);
        send(vecs[13], 1'b0);
        send(vecs[12], 1'b1);
        wait_done();
        chk("wrap_nwrites", 32'(wa_q.size()), 32'd2);
        if (wa_q.size() >= 2) begin
            chk("wrap_addr0", wa_q[0], 32'hFFFFFFFC);
            chk("wrap_data0", wd_q[0], 32'h34641234);
            chk("wrap_addr1", wa_q[1], 32'h00000000);
            chk("wrap_data1", wd_q[1], 32'h302200FF);
        end
        chk("wrap_next_addr", imem_addr, 32'h4);

        // reset during FLUSH
        imem_ready = 1'b0;
        start_session(32'h400);
        send(vecs[0], 1'b0);
        send(vecs[1], 1'b1);
        @(negedge clk);
        chk("flush_busy", 32'(busy), 32'h1);
        chk("flush_we", 32'(imem_we), 32'h1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        d0 = done_cnt;
        chk("mrst_we", 32'(imem_we), 32'h0);
        chk("mrst_busy", 32'(busy), 32'h0);
        chk("mrst_addr", imem_addr, 32'h0);
        imem_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("mrst_no_done", 32'(done_cnt - d0), 32'h0);
        chk("mrst_no_writes", 32'(wa_q.size()), 32'h0);
        chk("mrst_we_later", 32'(imem_we), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
